// File: rtl/cpu0_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu0_io_pkg
// Description : Shared size codes, register offsets and bit positions for the
//               CPU0 memory-mapped output port.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu0_io_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_INT16 = 2'b01;
    localparam logic [1:0] SZ_INT24 = 2'b10;
    localparam logic [1:0] SZ_INT32 = 2'b11;

    localparam logic [3:0] OFS_DATA   = 4'd0;
    localparam logic [3:0] OFS_STATUS = 4'd4;
    localparam logic [3:0] OFS_CTRL   = 4'd8;

    localparam int STAT_OVF_BIT     = 31;
    localparam int STAT_FULL_BIT    = 17;
    localparam int STAT_EMPTY_BIT   = 16;
    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;

    function automatic logic [31:0] size_mask(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            SZ_BYTE:  r = {24'h0, d[7:0]};
            SZ_INT16: r = {16'h0, d[15:0]};
            SZ_INT24: r = {8'h0, d[23:0]};
            default:  r = d;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu0_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cpu0_sync_fifo
// Description : Power-of-two synchronous FIFO with separate count register;
//               flush has priority over push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu0_sync_fifo
    import cpu0_io_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;

    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // Empty slots hold stale data, so the head reads as zero when empty.
    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/cpu0_out_port.sv
`default_nettype none
// ============================================================================
// Module      : cpu0_out_port
// Description : Memory-mapped output port on the CPU0 bus: DATA/STATUS/CTRL
//               registers in front of a FIFO drained over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu0_out_port
    import cpu0_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7000,
    parameter int          DEPTH     = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        rw,
    input  logic [1:0]  m_size,
    input  logic [31:0] abus,
    input  logic [31:0] dbus_in,
    output logic [31:0] dbus_out,
    output logic        hit,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          r_en_q;
    logic          r_armed;
    logic          r_overflow;
    logic [3:0]    w_ofs;
    logic          w_commit;
    logic          w_push;
    logic          w_ctrl_wr;
    logic          w_flush;
    logic          w_clr_ovf;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [31:0]   w_head;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;

    assign hit   = (abus[31:4] == BASE_ADDR[31:4]);
    assign w_ofs = abus[3:0] & 4'hC;

    // r_armed stays low after reset until en is seen low, so a store that
    // straddles reset never commits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_en_q  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_en_q <= en;
            if (!en) r_armed <= 1'b1;
        end
    end

    assign w_commit  = hit & en & ~rw & ~r_en_q & r_armed;
    assign w_push    = w_commit & (w_ofs == OFS_DATA);
    assign w_ctrl_wr = w_commit & (w_ofs == OFS_CTRL);
    assign w_flush   = w_ctrl_wr & dbus_in[CTRL_FLUSH_BIT];
    assign w_clr_ovf = w_ctrl_wr & dbus_in[CTRL_CLR_OVF_BIT];
    assign w_pop     = out_valid & out_ready;

    cpu0_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (size_mask(m_size, dbus_in)),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_clr_ovf) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop && !w_flush) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow  = r_overflow;
    assign out_data  = w_head;
    assign out_valid = ~w_empty;

    always_comb begin
        w_status                 = '0;
        w_status[CW-1:0]         = w_count;
        w_status[STAT_EMPTY_BIT] = w_empty;
        w_status[STAT_FULL_BIT]  = w_full;
        w_status[STAT_OVF_BIT]   = r_overflow;
    end

    always_comb begin
        w_rdata = '0;
        case (w_ofs)
            OFS_DATA:   w_rdata = w_head;
            OFS_STATUS: w_rdata = w_status;
            default:    w_rdata = '0;
        endcase
    end

    assign dbus_out = (hit & en & rw) ? w_rdata : 32'hZZZZ_ZZZZ;

endmodule
`default_nettype wire
